// File: rtl/i2s_tx_serializer.sv
// Philips-I2S transmitter for the ADAU1761: one-deep sample holding register, BCLK/LRCLK generation, underrun flag.
// Optional macro I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun loads silence instead of repeating the last frame.
module i2s_tx_serializer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  output logic              ready_o,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  output logic              frame_start_o,
  output logic              underrun_o
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned IDX_W      = $clog2(DATA_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              holding_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] frame_l;
  logic [DATA_W-1:0] frame_r;

  logic              rise_tick_c;
  logic              fall_tick_c;
  logic              wrap_c;
  logic              load_c;
  logic              accept_c;
  logic              holding_full_nxt_c;
  logic [CNT_W-1:0]  bit_nxt_c;
  logic [CNT_W-1:0]  right_pos_c;
  logic              lrclk_nxt_c;
  logic              sdata_nxt_c;

  // Tick decode, frame load and handshake bookkeeping
  always_comb begin
    rise_tick_c        = (div_cnt == DIV_W'(BCLK_DIV / 2 - 1));
    fall_tick_c        = (div_cnt == DIV_W'(BCLK_DIV - 1));
    wrap_c             = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    load_c             = fall_tick_c & wrap_c;
    accept_c           = valid_i & ready_o;
    holding_full_nxt_c = accept_c | (holding_full & ~load_c);
  end

  // Serial bit for the slot position that the coming fall tick moves to
  always_comb begin
    bit_nxt_c   = wrap_c ? '0 : bit_cnt + CNT_W'(1);
    right_pos_c = bit_nxt_c - CNT_W'(SLOT_W);
    lrclk_nxt_c = (bit_nxt_c >= CNT_W'(SLOT_W));
    sdata_nxt_c = 1'b0;
    if ((bit_nxt_c >= CNT_W'(1)) && (bit_nxt_c <= CNT_W'(DATA_W))) begin
      sdata_nxt_c = frame_l[IDX_W'(CNT_W'(DATA_W) - bit_nxt_c)];
    end else if ((bit_nxt_c >= CNT_W'(SLOT_W + 1)) &&
                 (bit_nxt_c <= CNT_W'(SLOT_W + DATA_W))) begin
      sdata_nxt_c = frame_r[IDX_W'(CNT_W'(DATA_W) - right_pos_c)];
    end
  end

  // Bit-clock divider and serial output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk_o  <= 1'b0;
      lrclk_o <= 1'b0;
      sdata_o <= 1'b0;
    end else begin
      div_cnt <= fall_tick_c ? '0 : div_cnt + DIV_W'(1);
      if (rise_tick_c) begin
        bclk_o <= 1'b1;
      end
      if (fall_tick_c) begin
        bclk_o  <= 1'b0;
        bit_cnt <= bit_nxt_c;
        lrclk_o <= lrclk_nxt_c;
        sdata_o <= sdata_nxt_c;
      end
    end
  end

  // Holding register and producer handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holding_full <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      ready_o      <= 1'b1;
    end else begin
      holding_full <= holding_full_nxt_c;
      ready_o      <= ~holding_full_nxt_c;
      if (accept_c) begin
        hold_l <= left_i;
        hold_r <= right_i;
      end
    end
  end

  // Frame registers and per-frame status pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_l       <= '0;
      frame_r       <= '0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      frame_start_o <= load_c;
      underrun_o    <= load_c & ~holding_full;
      if (load_c) begin
        if (holding_full) begin
          frame_l <= hold_l;
          frame_r <= hold_r;
        end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          frame_l <= '0;
          frame_r <= '0;
`else
          frame_l <= frame_l;
          frame_r <= frame_r;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: cycle-count based frame model plus directed literal checks.
module tb_i2s_tx_serializer;

  localparam int unsigned DATA_W   = 24;
  localparam int unsigned SLOT_W   = 32;
  localparam int unsigned BCLK_DIV = 4;
  localparam int          FRAME_CLK = 2 * SLOT_W * BCLK_DIV;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] left  = '0;
  logic [DATA_W-1:0] right = '0;
  logic              ready;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              frame_start;
  logic              underrun;

  i2s_tx_serializer #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .left_i       (left),
    .right_i      (right),
    .ready_o      (ready),
    .bclk_o       (bclk),
    .lrclk_o      (lrclk),
    .sdata_o      (sdata),
    .frame_start_o(frame_start),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  // Model state: clock edges since release, pending pair, frame on air
  int                m_k     = 0;
  pair_t             m_pend[$];
  logic [DATA_W-1:0] m_cur_l = '0;
  logic [DATA_W-1:0] m_cur_r = '0;
  logic              m_fs    = 1'b0;
  logic              m_ur    = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %b expected %b", name, m_k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", name, m_k, act, exp);
    end
  endtask

  function automatic logic exp_bclk(input int k);
    int c;
    if (k == 0) return 1'b0;
    c = (k - 1) % BCLK_DIV;
    return (c >= int'(BCLK_DIV / 2 - 1)) && (c <= int'(BCLK_DIV - 2));
  endfunction

  function automatic int bit_pos(input int k);
    return (k / BCLK_DIV) % (2 * SLOT_W);
  endfunction

  function automatic logic exp_sdata(input int b, input logic [DATA_W-1:0] l,
                                     input logic [DATA_W-1:0] r);
    if (b >= 1 && b <= DATA_W) return l[DATA_W - b];
    if (b >= SLOT_W + 1 && b <= SLOT_W + DATA_W) return r[DATA_W - (b - SLOT_W)];
    return 1'b0;
  endfunction

  // Model: frame loads every FRAME_CLK clocks, one pending pair, accept while nothing pending
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_k = 0;
      m_pend.delete();
      m_cur_l = '0;
      m_cur_r = '0;
      m_fs = 1'b0;
      m_ur = 1'b0;
    end else begin
      bit    load;
      bit    acc;
      pair_t p;
      load = ((m_k + 1) % FRAME_CLK) == 0;
      acc  = valid && (m_pend.size() == 0);
      p.l  = left;
      p.r  = right;
      m_fs = load;
      m_ur = 1'b0;
      if (load) begin
        if (m_pend.size() > 0) begin
          pair_t q;
          q = m_pend.pop_front();
          m_cur_l = q.l;
          m_cur_r = q.r;
        end else begin
          m_ur = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          m_cur_l = '0;
          m_cur_r = '0;
`endif
        end
      end
      if (acc) m_pend.push_back(p);
      m_k++;
    end
  end

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    check1("bclk", bclk, exp_bclk(m_k));
    check1("lrclk", lrclk, bit_pos(m_k) >= int'(SLOT_W));
    check1("sdata", sdata, exp_sdata(bit_pos(m_k), m_cur_l, m_cur_r));
    check1("ready", ready, m_pend.size() == 0);
    check1("frame_start", frame_start, m_fs);
    check1("underrun", underrun, m_ur);
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (m_k < target) begin
      @(posedge clk);
      #2;
      guard++;
      if (guard > 20000) begin
        check_int("wait_k_timeout", m_k, target);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got k=%0d expected completion", m_k);
    $fatal(1);
  end

  initial begin
    int    n_acc;
    int    cnt;
    logic  acc;

    repeat (3) @(posedge clk);
    #2;
    check1("rst_ready", ready, 1'b1);
    check1("rst_bclk", bclk, 1'b0);
    check1("rst_sdata", sdata, 1'b0);
    check1("rst_underrun", underrun, 1'b0);
    rst = 1'b0;

    // Idle stream: divider, word select and underrun cadence
    wait_k(2);   check1("lit_bclk_hi", bclk, 1'b1);
    wait_k(4);   check1("lit_bclk_lo", bclk, 1'b0);
    wait_k(127); check1("lit_lrclk_left", lrclk, 1'b0);
    wait_k(128); check1("lit_lrclk_right", lrclk, 1'b1);
    wait_k(255); check1("lit_ur_before", underrun, 1'b0);
    wait_k(256); check1("lit_ur_256", underrun, 1'b1);
                 check1("lit_fs_256", frame_start, 1'b1);
    wait_k(257); check1("lit_ur_257", underrun, 1'b0);
    wait_k(512); check1("lit_ur_512", underrun, 1'b1);

    // Single pair A5A5A5 / 5A5A5A
    wait_k(600);
    valid = 1'b1; left = 24'hA5A5A5; right = 24'h5A5A5A;
    wait_k(601);
    valid = 1'b0;
    check1("lit_ready_busy", ready, 1'b0);
    wait_k(767); check1("lit_ready_767", ready, 1'b0);
    wait_k(768); check1("lit_fs_768", frame_start, 1'b1);
                 check1("lit_ur_768", underrun, 1'b0);
                 check1("lit_ready_768", ready, 1'b1);
    wait_k(772); check1("lit_a5_b1", sdata, 1'b1);
    wait_k(776); check1("lit_a5_b2", sdata, 1'b0);
    wait_k(868); check1("lit_pad_b25", sdata, 1'b0);
    wait_k(900); check1("lit_5a_b33", sdata, 1'b0);
    wait_k(904); check1("lit_5a_b34", sdata, 1'b1);

    // Extremes, then starve the holding register
    wait_k(910);
    valid = 1'b1; left = 24'h800001; right = 24'h7FFFFF;
    wait_k(911);
    valid = 1'b0;
    wait_k(1028); check1("lit_800001_b1", sdata, 1'b1);
    wait_k(1156); check1("lit_7fffff_b33", sdata, 1'b0);
    wait_k(1160); check1("lit_7fffff_b34", sdata, 1'b1);
    wait_k(1280); check1("lit_ur_1280", underrun, 1'b1);
    wait_k(1284);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    check1("lit_mute_b1", sdata, 1'b0);
`else
    check1("lit_hold_b1", sdata, 1'b1);
`endif

    // Continuous valid with counter payload
    wait_k(1290);
    cnt = 0; n_acc = 0;
    valid = 1'b1; left = 24'h100000; right = 24'h200000;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk);
      #2;
      if (acc) begin
        n_acc++;
        cnt++;
        left  = 24'h100000 + DATA_W'(cnt);
        right = 24'h200000 + DATA_W'(cnt);
      end
    end
    valid = 1'b0;
    check_int("lit_accept_count", n_acc, 5);
    wait_k(2576); check1("lit_cnt4_b4", sdata, 1'b1);

    // Offer a pair in the exact load cycle with holding empty
    wait_k(2815);
    valid = 1'b1; left = 24'h123456; right = 24'hABCDEF;
    wait_k(2816);
    valid = 1'b0;
    check1("lit_ur_2816", underrun, 1'b1);
    check1("lit_fs_2816", frame_start, 1'b1);
    check1("lit_ready_2816", ready, 1'b0);
    wait_k(3072); check1("lit_fs_3072", frame_start, 1'b1);
                  check1("lit_ur_3072", underrun, 1'b0);
    wait_k(3088); check1("lit_123456_b4", sdata, 1'b1);

    // Fill holding, then reset mid-frame at bit 40
    wait_k(3100);
    valid = 1'b1; left = 24'hFFFFFF; right = 24'hFFFFFF;
    wait_k(3101);
    valid = 1'b0;
    wait_k(3233);
    check1("lit_pre_rst_lrclk", lrclk, 1'b1);
    check1("lit_pre_rst_ready", ready, 1'b0);
    rst = 1'b1;
    #1;
    check1("lit_midrst_bclk", bclk, 1'b0);
    check1("lit_midrst_lrclk", lrclk, 1'b0);
    check1("lit_midrst_sdata", sdata, 1'b0);
    check1("lit_midrst_ready", ready, 1'b1);
    check1("lit_midrst_fs", frame_start, 1'b0);
    check1("lit_midrst_ur", underrun, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_k(256); check1("lit_post_rst_ur", underrun, 1'b1);
    wait_k(260); check1("lit_post_rst_sdata", sdata, 1'b0);
    wait_k(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
